// File: rtl/priority_encoder_seg.sv
// Segmented two-ended priority encoder: highest/lowest set bit as one-hot and index, plus empty flag.
// Latency: s cycles from accept to data_val_o (s = scan depth needed by the slower search, 1..NSEG).
// Backpressure: data_ready_o is low for the whole scan; data_val_i is ignored while busy, never queued.
module priority_encoder_seg #(
    parameter int WIDTH     = 16,
    parameter int SEG_WIDTH = 4,
    localparam int IDX_W    = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] data_left_o,
    output logic [WIDTH-1:0] data_right_o,
    output logic [IDX_W-1:0] data_left_idx_o,
    output logic [IDX_W-1:0] data_right_idx_o,
    output logic             data_empty_o,
    output logic             data_val_o
);

    localparam int NSEG  = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
    localparam int PAD_W = NSEG * SEG_WIDTH;
    localparam int KW    = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);

    typedef enum logic {IDLE, SCAN} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
        logic [IDX_W-1:0] left_idx;
        logic [IDX_W-1:0] right_idx;
        logic             empty;
    } result_t;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] data_q;
    logic [PAD_W-1:0] data_pad;
    logic [KW-1:0]    k_q;
    logic             l_found_q;
    logic             r_found_q;
    logic [IDX_W-1:0] l_idx_q;
    logic [IDX_W-1:0] r_idx_q;
    logic             l_hit;
    logic             r_hit;
    logic [IDX_W-1:0] l_new;
    logic [IDX_W-1:0] r_new;
    logic             l_found_d;
    logic             r_found_d;
    logic [IDX_W-1:0] l_idx_d;
    logic [IDX_W-1:0] r_idx_d;
    logic             accept;
    logic             done;
    result_t          res_d;
    result_t          res_q;
    logic             val_q;

    // Bits beyond WIDTH in the top segment are padded with zero so they never hit.
    assign data_pad = PAD_W'(data_q);

    // Left search looks at segment NSEG-1-k, right search at segment k.
    always_comb begin
        l_hit = 1'b0;
        l_new = '0;
        r_hit = 1'b0;
        r_new = '0;
        for (int j = 0; j < NSEG; j++) begin
            if (KW'(NSEG - 1 - j) == k_q) begin
                for (int b = 0; b < SEG_WIDTH; b++) begin
                    if (data_pad[j*SEG_WIDTH + b]) begin
                        l_hit = 1'b1;
                        l_new = IDX_W'(j*SEG_WIDTH + b);
                    end
                end
            end
            if (KW'(j) == k_q) begin
                for (int b = SEG_WIDTH - 1; b >= 0; b--) begin
                    if (data_pad[j*SEG_WIDTH + b]) begin
                        r_hit = 1'b1;
                        r_new = IDX_W'(j*SEG_WIDTH + b);
                    end
                end
            end
        end
    end

    always_comb begin
        l_found_d = l_found_q;
        l_idx_d   = l_idx_q;
        r_found_d = r_found_q;
        r_idx_d   = r_idx_q;
        if (!l_found_q && l_hit) begin
            l_found_d = 1'b1;
            l_idx_d   = l_new;
        end
        if (!r_found_q && r_hit) begin
            r_found_d = 1'b1;
            r_idx_d   = r_new;
        end
    end

    assign accept = data_val_i && (state_q == IDLE);
    assign done   = (state_q == SCAN) && ((l_found_d && r_found_d) || (k_q == K_LAST));

    // Indices stay at their cleared value of 0 when nothing is found, giving the all-zero response.
    always_comb begin
        res_d           = '0;
        res_d.left_idx  = l_idx_d;
        res_d.right_idx = r_idx_d;
        res_d.empty     = !l_found_d;
        for (int i = 0; i < WIDTH; i++) begin
            res_d.left[i]  = l_found_d && (IDX_W'(i) == l_idx_d);
            res_d.right[i] = r_found_d && (IDX_W'(i) == r_idx_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_val_i) state_d = SCAN;
            SCAN:    if (done)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_ready_o = (state_q == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_q    <= '0;
            k_q       <= '0;
            l_found_q <= 1'b0;
            r_found_q <= 1'b0;
            l_idx_q   <= '0;
            r_idx_q   <= '0;
            res_q     <= '0;
            val_q     <= 1'b0;
        end else begin
            val_q <= done;
            if (accept) begin
                data_q    <= data_i;
                k_q       <= '0;
                l_found_q <= 1'b0;
                r_found_q <= 1'b0;
                l_idx_q   <= '0;
                r_idx_q   <= '0;
            end else if (state_q == SCAN && !done) begin
                k_q       <= k_q + KW'(1);
                l_found_q <= l_found_d;
                r_found_q <= r_found_d;
                l_idx_q   <= l_idx_d;
                r_idx_q   <= r_idx_d;
            end
            if (done) begin
                res_q <= res_d;
            end
        end
    end

    assign data_left_o      = res_q.left;
    assign data_right_o     = res_q.right;
    assign data_left_idx_o  = res_q.left_idx;
    assign data_right_idx_o = res_q.right_idx;
    assign data_empty_o     = res_q.empty;
    assign data_val_o       = val_q;

endmodule

// File: doc/priority_encoder_seg.md
# priority_encoder_seg

Multi-cycle, parametrised priority encoder. It captures a WIDTH-bit word and scans it segment by segment, searching from both ends at once. It reports the most-significant and least-significant set bits as one-hot vectors and as binary indices, plus an empty flag. It is the wide-word successor to the single-cycle left/right encoder, with a ready/valid input handshake, early termination and a defined all-zero response.

## Interface
- WIDTH, 16, input word width; WIDTH >= 2.
- SEG_WIDTH, 4, bits examined per scan cycle from each end; 1 <= SEG_WIDTH <= WIDTH.
- Derived: NSEG = ceil(WIDTH/SEG_WIDTH); IDX_W = max(1, $clog2(WIDTH)).
- clk_i  in  1  single clock; all logic on rising edge.
- srst_i  in  1  synchronous, active-high reset.
- data_i  in  WIDTH  word to encode; sampled only on accept.
- data_val_i  in  1  input valid.
- data_ready_o  out  1  block idle and able to accept.
- data_left_o  out  WIDTH  one-hot copy of the highest set bit; 0 if empty.
- data_right_o  out  WIDTH  one-hot copy of the lowest set bit; 0 if empty.
- data_left_idx_o  out  IDX_W  index of the highest set bit; 0 if empty.
- data_right_idx_o  out  IDX_W  index of the lowest set bit; 0 if empty.
- data_empty_o  out  1  captured word was all zero.
- data_val_o  out  1  one-cycle strobe: the result outputs are updated.

## Operation
- **States:** IDLE, SCAN.
- **Accept:** an accept occurs on an edge where data_val_i && data_ready_o.
  - data_i is registered and the segment counter k is cleared to 0.
  - The left-found and right-found flags are cleared.
  - The FSM moves IDLE -> SCAN.
- **data_ready_o:** equals (state == IDLE). data_val_i is ignored in SCAN; input is not queued.
- **Segments:** segment j covers bits [j*SEG_WIDTH +: SEG_WIDTH]. Bits at index >= WIDTH in the top segment read as 0.
- **Each SCAN edge:**
  - If the left search has not yet found a bit, it examines segment NSEG-1-k and latches the highest set bit in that segment, if any.
  - If the right search has not yet found a bit, it examines segment k and latches the lowest set bit in that segment, if any.
  - k then increments.
- **Termination:** on the SCAN edge where both searches have found a bit, or where k == NSEG-1:
  - All result outputs are loaded.
  - data_val_o is set.
  - The FSM returns to IDLE.
- **Empty word:** both searches run all NSEG cycles. On termination the one-hot outputs and indices are 0 and data_empty_o = 1. Otherwise data_empty_o = 0.
- **Single set bit:** left and right report the same bit.
- **Result hold:** result outputs hold their value between data_val_o strobes.
- **Reset:** srst_i overrides everything, including mid-scan.
  - The scan in progress is aborted and no data_val_o is produced for it.
  - The FSM goes to IDLE, so data_ready_o = 1 in the cycle after reset.
  - Reset values: data_left_o, data_right_o, both indices, data_empty_o and data_val_o = 0; internal registers cleared.

## Timing
- Let s = max(left hit position, right hit position) + 1, where:
  - the left hit position is the value of k at which the left search finds its bit;
  - the right hit position is the value of k at which the right search finds its bit;
  - s = NSEG for an all-zero word. Range: 1 <= s <= NSEG.
- Accept on edge E0. Scan edges are E1..Es. data_val_o is high for exactly one cycle, beginning at edge Es.
- Latency from accept to result is s cycles.
- data_ready_o falls at E0 and rises at Es, in the same cycle as data_val_o.
- A new accept is legal in the data_val_o cycle, so back-to-back throughput is one word per s+1 cycles.
- Outputs are registered; there is no combinational path from data_i to any output.

## Test plan
- **Two bits set** (WIDTH=16, SEG_WIDTH=4): data_i=16'h0810 -> left=16'h0800, idx 11; right=16'h0010, idx 4; empty=0; data_val_o 2 cycles after accept.
- **End bits:** data_i=16'h8001 -> left idx 15, right idx 0; s=1, so data_val_o at E1 and ready high again at E1.
- **All zero:** data_i=16'h0000 -> all one-hot and index outputs 0, data_empty_o=1, s=4.
- **Single bit:** data_i=16'h0020 -> left=right=16'h0020, both indices 5, s=3.
- **Partial top segment** (WIDTH=7, SEG_WIDTH=3): data_i=7'b1000000 -> left=right=7'b1000000, idx 6, s=3. Separately, 7'b0000101 -> left idx 2, right idx 0, s=3.
- **Handshake and reset:**
  - data_val_i held high: accepts occur only when data_ready_o=1; no extra data_val_o strobes.
  - srst_i pulsed one cycle mid-scan of 16'h0000: no data_val_o; outputs all 0; data_ready_o=1 the next cycle.
  - A new word accepted after the reset yields a correct result.
